multi_pulse_gen: RTL

Parametrised multi-pulse gate-drive generator for the PCB switching-test rig; the generalised successor to the fixed double-pulse tester. On a trigger edge it emits a burst of N pulses on `k1` with runtime-programmable first-pulse width, pulse width, gap and post-burst holdoff. Optionally it drives a complementary, dead-time-protected `k2` for half-bridge tests.

---
 rtl/pulse_test_pkg.sv | 25 ++
 rtl/dead_time_gen.sv | 56 +++++
 rtl/multi_pulse_gen.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pulse_test_pkg.sv
// ----------------------------------------------------------------------------
// pulse_test_pkg
//   Shared definitions for the multi-pulse gate-drive generator:
//     - pulse_state_t : burst sequencer states
//     - CLK_HZ        : nominal system clock (40 MHz)
//     - T_*           : default phase lengths in clk cycles for the rig
//                       (30 us first pulse, 30 us pulses, 20 us gap, 5 s holdoff)
// ----------------------------------------------------------------------------
package pulse_test_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FIRST_HIGH,
        LOW,
        HIGH,
        HOLDOFF
    } pulse_state_t;

    localparam int unsigned CLK_HZ       = 40_000_000;
    localparam int unsigned T_FIRST_HIGH = 1200;
    localparam int unsigned T_HIGH       = 1200;
    localparam int unsigned T_LOW        = 800;
    localparam int unsigned T_HOLDOFF    = 200_000_000;

endpackage

// File: rtl/dead_time_gen.sv
// ----------------------------------------------------------------------------
// dead_time_gen
//   Registered complementary drive k2 for half-bridge tests. k2 is high only
//   inside a LOW phase, from phase cycle DEAD_CYC to (low_len - DEAD_CYC - 1),
//   so there are DEAD_CYC both-low cycles after every k1 fall and before every
//   k1 rise. Gaps of 2*DEAD_CYC cycles or less never raise k2.
//   Intended for DEAD_CYC >= 1.
//
//   Ports:
//     clk, rst_n : system clock, async active-low reset
//     state      : current sequencer state
//     abort      : synchronous burst abort (forces k2 low next cycle)
//     cnt        : phase counter (cycle index within the current phase)
//     low_len    : latched gap length, already clamped to >= 1
//     k2         : complementary drive, registered
// ----------------------------------------------------------------------------
module dead_time_gen
    import pulse_test_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int DEAD_CYC = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  pulse_state_t     state,
    input  logic             abort,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] low_len,
    output logic             k2
);

    // Two spare bits so idx + DEAD + 1 can never overflow.
    localparam int XW = CNT_W + 2;
    localparam logic [XW-1:0] DEAD = XW'(DEAD_CYC);
    localparam logic [XW-1:0] X_ONE = XW'(1);

    logic [XW-1:0] idx_next;
    logic          k2_next;

    // k2 is registered, so decide from the index of the *next* cycle. When the
    // LOW phase is about to end idx_next equals low_len and the window test
    // fails, so no separate end-of-phase term is needed.
    assign idx_next = XW'(cnt) + X_ONE;
    assign k2_next  = (state == LOW) && !abort &&
                      (idx_next >= DEAD) &&
                      (idx_next + DEAD + X_ONE <= XW'(low_len));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k2 <= 1'b0;
        end else begin
            k2 <= k2_next;
        end
    end

endmodule

// File: rtl/multi_pulse_gen.sv
// ----------------------------------------------------------------------------
// multi_pulse_gen
//   Multi-pulse gate-drive generator. A rising edge on trig (in IDLE) starts a
//   burst: one first pulse, then (gap, pulse) repeated npulse-1 times, then a
//   holdoff lockout. Every phase programmed with V lasts max(V,1) cycles.
//   Optional macro MULTI_PULSE_DEADTIME_EN adds the complementary,
//   dead-time-protected k2 output; without it k2 is a registered 0.
//
//   Ports:
//     clk, rst_n      : 40 MHz system clock, async active-low reset
//     trig            : asynchronous trigger, rising edge starts a burst
//     enable          : gates pulses 2..N (k1 = enable in HIGH)
//     abort           : ends a running burst, goes to HOLDOFF
//     cfg_first_high  : width of pulse 1
//     cfg_high        : width of pulses 2..N
//     cfg_low         : gap between pulses
//     cfg_holdoff     : post-burst lockout
//     cfg_npulse      : pulses per burst (0 treated as 1)
//     k1, k2          : gate drives, registered
//     busy            : high in every state except IDLE
//     done            : one-cycle pulse in the first HOLDOFF cycle
//     dbg_state       : current sequencer state
// ----------------------------------------------------------------------------
module multi_pulse_gen
    import pulse_test_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int NP_W     = 4,
    parameter int DEAD_CYC = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig,
    input  logic             enable,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_first_high,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_low,
    input  logic [CNT_W-1:0] cfg_holdoff,
    input  logic [NP_W-1:0]  cfg_npulse,
    output logic             k1,
    output logic             k2,
    output logic             busy,
    output logic             done,
    output pulse_state_t     dbg_state
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [NP_W-1:0]  NP_ONE  = NP_W'(1);

    pulse_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [NP_W-1:0]  pcnt;
    logic [CNT_W-1:0] fh_len, hi_len, lo_len, ho_len;
    logic [NP_W-1:0]  np_len;
    logic [CNT_W-1:0] phase_last;
    logic [NP_W-1:0]  np_last;
    logic             trig_s1, trig_s2, trig_s3;
    logic             trig_rise;

    function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_ONE : v;
    endfunction

    function automatic logic [NP_W-1:0] clamp_np(input logic [NP_W-1:0] v);
        return (v == '0) ? NP_ONE : v;
    endfunction

    // trig_s1/s2 form the synchronizer; trig_s3 only delays s2 for edge
    // detection. The rise is a single-cycle pulse, so an edge arriving while
    // the sequencer is not in IDLE is simply lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
            trig_s3 <= 1'b0;
        end else begin
            trig_s1 <= trig;
            trig_s2 <= trig_s1;
            trig_s3 <= trig_s2;
        end
    end

    assign trig_rise = trig_s2 & ~trig_s3;

    // Last counter value of the current phase (lengths are stored clamped).
    always_comb begin
        phase_last = ho_len - CNT_ONE;
        case (state)
            FIRST_HIGH: phase_last = fh_len - CNT_ONE;
            LOW:        phase_last = lo_len - CNT_ONE;
            HIGH:       phase_last = hi_len - CNT_ONE;
            default:    ;
        endcase
    end

    assign np_last = np_len - NP_ONE;

    // pcnt holds the index of the pulse currently being emitted (0-based).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            pcnt   <= '0;
            fh_len <= '0;
            hi_len <= '0;
            lo_len <= '0;
            ho_len <= '0;
            np_len <= '0;
            k1     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig_rise) begin
                        fh_len <= clamp_cnt(cfg_first_high);
                        hi_len <= clamp_cnt(cfg_high);
                        lo_len <= clamp_cnt(cfg_low);
                        ho_len <= clamp_cnt(cfg_holdoff);
                        np_len <= clamp_np(cfg_npulse);
                        cnt    <= '0;
                        pcnt   <= '0;
                        state  <= FIRST_HIGH;
                        k1     <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                FIRST_HIGH, LOW, HIGH: begin
                    if (abort) begin
                        state <= HOLDOFF;
                        cnt   <= '0;
                        k1    <= 1'b0;
                        done  <= 1'b1;
                    end else if (cnt == phase_last) begin
                        cnt <= '0;
                        if (state == LOW) begin
                            state <= HIGH;
                            k1    <= enable;
                        end else if (pcnt == np_last) begin
                            state <= HOLDOFF;
                            k1    <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= LOW;
                            k1    <= 1'b0;
                            pcnt  <= pcnt + NP_ONE;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                        k1  <= (state == FIRST_HIGH) ? 1'b1 :
                               (state == HIGH)       ? enable : 1'b0;
                    end
                end
                HOLDOFF: begin
                    if (cnt == phase_last) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    k1    <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

`ifdef MULTI_PULSE_DEADTIME_EN
    dead_time_gen #(
        .CNT_W    (CNT_W),
        .DEAD_CYC (DEAD_CYC)
    ) u_dead_time (
        .clk     (clk),
        .rst_n   (rst_n),
        .state   (state),
        .abort   (abort),
        .cnt     (cnt),
        .low_len (lo_len),
        .k2      (k2)
    );
`else
    logic unused_dead_cyc;
    assign unused_dead_cyc = ^DEAD_CYC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k2 <= 1'b0;
        end else begin
            k2 <= 1'b0;
        end
    end
`endif

endmodule
